sram_wait_model: RTL and testbench

//  Parametrised behavioural SRAM for the processor bench. It succeeds the fixed 64-bit/17-bit,

---
 rtl/sram_wait_model_if.sv | 27 ++
 rtl/sram_wait_model.sv | 131 +++++++++++++
 tb/tb_sram_wait_model.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_wait_model_if.sv
// Control/status bundle between an SRAM controller and sram_wait_model.
// SRAM_DQ is bidirectional and travels as a separate inout port on the model.
interface sram_wait_model_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 17
);
  logic                  SRAM_CE_N;
  logic                  SRAM_WE_N;
  logic                  SRAM_OE_N;
  logic [DATA_W/8-1:0]   SRAM_BE_N;
  logic [ADDR_W-1:0]     SRAM_ADDR;
  logic                  SRAM_RDY;
  logic                  SRAM_ERR;
  // Debug taps: FSM state (0 = IDLE, 1 = BUSY, 2 = DONE) and per-lane DQ drive enables.
  logic [1:0]            dbg_state;
  logic [DATA_W/8-1:0]   dbg_dq_oe;

  modport master (
    output SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_BE_N, SRAM_ADDR,
    input  SRAM_RDY, SRAM_ERR, dbg_state, dbg_dq_oe
  );

  modport slave (
    input  SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_BE_N, SRAM_ADDR,
    output SRAM_RDY, SRAM_ERR, dbg_state, dbg_dq_oe
  );
endinterface

// File: rtl/sram_wait_model.sv
// Behavioural SRAM with configurable latency, byte-lane writes, abort on CE_N
// release and a sticky error flag for request changes while an access is in flight.
module sram_wait_model #(
  parameter int                DATA_W   = 64,
  parameter int                ADDR_W   = 17,
  parameter int                DEPTH    = 65536,
  parameter int                LAT      = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_wait_model_if.slave   bus,
  inout  wire  [DATA_W-1:0]  SRAM_DQ
);
  // Handshake: CE_N=0 at an IDLE edge is a request; it must stay low with stable
  // ADDR/WE_N/BE_N until SRAM_RDY, which pulses for exactly one cycle (DONE).
  // Raising CE_N before completion aborts the access without a RDY pulse.

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we_n;
  logic [LANES-1:0]  cap_be_n;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] rd_q;
  logic [LANES-1:0]  lane_oe;

  // Memory survives reset; INIT_VAL is a power-up value only.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

  logic              commit;
  logic [IDX_W-1:0]  c_idx;
  logic              c_we_n;
  logic [LANES-1:0]  c_be_n;
  logic [DATA_W-1:0] c_data;
  logic              mismatch;

  assign mismatch = (bus.SRAM_ADDR != cap_addr) || (bus.SRAM_WE_N != cap_we_n) ||
                    (bus.SRAM_BE_N != cap_be_n);

  // With LAT==1 the accept edge is also the completion edge, so commit from the live bus.
  always_comb begin
    commit = 1'b0;
    c_idx  = cap_addr[IDX_W-1:0];
    c_we_n = cap_we_n;
    c_be_n = cap_be_n;
    c_data = cap_data;
    if (rst_n && !bus.SRAM_CE_N) begin
      if (state == IDLE && LAT == 1) begin
        commit = 1'b1;
        c_idx  = bus.SRAM_ADDR[IDX_W-1:0];
        c_we_n = bus.SRAM_WE_N;
        c_be_n = bus.SRAM_BE_N;
        c_data = SRAM_DQ;
      end else if (state == BUSY && cnt == '0) begin
        commit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= 1'b0;
      cap_addr <= '0;
      cap_we_n <= 1'b1;
      cap_be_n <= '1;
      cap_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.SRAM_CE_N) begin
            cap_addr <= bus.SRAM_ADDR;
            cap_we_n <= bus.SRAM_WE_N;
            cap_be_n <= bus.SRAM_BE_N;
            if (!bus.SRAM_WE_N) cap_data <= SRAM_DQ;
            if (LAT == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(LAT - 1);
            end
          end
        end
        BUSY: begin
          if (bus.SRAM_CE_N) begin
            state <= IDLE;
          end else begin
            if (mismatch) err <= 1'b1;
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      if (c_we_n) begin
        rd_q <= mem[c_idx];
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (!c_be_n[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_oe[g] = (state == DONE) && cap_we_n && !bus.SRAM_OE_N && !cap_be_n[g];
    assign SRAM_DQ[8*g +: 8] = lane_oe[g] ? rd_q[8*g +: 8] : 8'bz;
  end

  assign bus.SRAM_RDY  = (state == DONE);
  assign bus.SRAM_ERR  = err;
  assign bus.dbg_state = state;
  assign bus.dbg_dq_oe = lane_oe;
endmodule

// File: tb/tb_sram_wait_model.sv
// Directed and randomized bench for sram_wait_model (64-bit, 1024 words, LAT=2)
// checked against an array-based memory model.
module tb_sram_wait_model;
  localparam int                DATA_W   = 64;
  localparam int                ADDR_W   = 17;
  localparam int                DEPTH    = 1024;
  localparam int                LAT      = 2;
  localparam logic [DATA_W-1:0] INIT_VAL = 64'h5A5A_5A5A_5A5A_5A5A;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] dq_drv;
  logic              dq_drv_en;
  wire  [DATA_W-1:0] dq;

  int total  = 0;
  int passed = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic              model_err;
  logic [DATA_W-1:0] exp_q [$];

  assign dq = dq_drv_en ? dq_drv : 'z;

  sram_wait_model_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sram_wait_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .SRAM_DQ (dq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] lanes);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (lanes[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // One complete access; bump changes ADDR after accept to provoke a protocol error.
  task automatic access(input bit wr, input logic [ADDR_W-1:0] addr, input logic [7:0] be_n,
                        input logic [63:0] data, input bit oe_n, input bit bump);
    int          idx = int'(addr) % DEPTH;
    logic [7:0]  exp_oe;
    logic [63:0] m;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = !wr;
    bus.SRAM_OE_N = oe_n;
    bus.SRAM_BE_N = be_n;
    bus.SRAM_ADDR = addr;
    dq_drv        = data;
    dq_drv_en     = wr;
    tick();
    if (bump) begin
      bus.SRAM_ADDR = addr + 1'b1;
      model_err     = 1'b1;
    end
    for (int i = 0; i < LAT; i++) begin
      chk("rdy_busy", 64'(bus.SRAM_RDY), 64'd0);
      tick();
    end
    exp_oe = (wr || oe_n) ? 8'h00 : ~be_n;
    m      = lane_mask(exp_oe);
    exp_q.push_back(model_mem[idx]);
    chk("rdy_done", 64'(bus.SRAM_RDY), 64'd1);
    chk("dq_oe", 64'(bus.dbg_dq_oe), 64'(exp_oe));
    chk("dq_data", dq & m, exp_q.pop_front() & m);
    chk("err", 64'(bus.SRAM_ERR), 64'(model_err));
    if (wr) begin
      for (int i = 0; i < 8; i++)
        if (!be_n[i]) model_mem[idx][8*i +: 8] = data[8*i +: 8];
    end
    bus.SRAM_CE_N = 1'b1;
    dq_drv_en     = 1'b0;
    tick();
    chk("rdy_after", 64'(bus.SRAM_RDY), 64'd0);
    chk("dq_oe_after", 64'(bus.dbg_dq_oe), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_VAL;
    model_err     = 1'b0;
    rst_n         = 1'b0;
    dq_drv        = '0;
    dq_drv_en     = 1'b0;
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_BE_N = '1;
    bus.SRAM_ADDR = '0;
    repeat (3) tick();
    chk("reset_rdy", 64'(bus.SRAM_RDY), 64'd0);
    chk("reset_err", 64'(bus.SRAM_ERR), 64'd0);
    chk("reset_oe", 64'(bus.dbg_dq_oe), 64'd0);
    chk("reset_state", 64'(bus.dbg_state), 64'd0);
    rst_n = 1'b1;
    tick();

    // full-word write then read back
    access(1, 17'd5, 8'h00, 64'hDEADBEEF_01234567, 0, 0);
    access(0, 17'd5, 8'h00, 64'h0, 0, 0);
    // single-lane write merges with old contents
    access(1, 17'd5, 8'hFE, 64'h00000000_000000AA, 0, 0);
    access(0, 17'd5, 8'h00, 64'h0, 0, 0);
    chk("merge_model", model_mem[5], 64'hDEADBEEF_012345AA);
    // address wrap: 1027 aliases word 3
    access(1, 17'd1027, 8'h00, 64'h1, 0, 0);
    access(0, 17'd3, 8'h00, 64'h0, 0, 0);
    // OE_N high: no drive, RDY still pulses
    access(0, 17'd3, 8'h00, 64'h0, 1, 0);
    // partial read lanes
    access(0, 17'd5, 8'hF0, 64'h0, 0, 0);

    // abort: CE_N released during BUSY
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    bus.SRAM_BE_N = 8'h00;
    bus.SRAM_ADDR = 17'd7;
    dq_drv        = 64'h55;
    dq_drv_en     = 1'b1;
    tick();
    bus.SRAM_CE_N = 1'b1;
    dq_drv_en     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_rdy", 64'(bus.SRAM_RDY), 64'd0);
    end
    access(0, 17'd7, 8'h00, 64'h0, 0, 0);

    // address changed mid-BUSY: error set, captured address still used
    access(1, 17'd11, 8'h00, 64'hCAFE_F00D_1234_5678, 0, 1);
    access(0, 17'd11, 8'h00, 64'h0, 0, 0);
    access(0, 17'd12, 8'h00, 64'h0, 0, 0);

    // reset during BUSY of a write drops it and clears ERR at once
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    bus.SRAM_BE_N = 8'h00;
    bus.SRAM_ADDR = 17'd9;
    dq_drv        = 64'h99;
    dq_drv_en     = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_rdy", 64'(bus.SRAM_RDY), 64'd0);
    chk("rst_err", 64'(bus.SRAM_ERR), 64'd0);
    chk("rst_oe", 64'(bus.dbg_dq_oe), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'd0);
    model_err     = 1'b0;
    bus.SRAM_CE_N = 1'b1;
    dq_drv_en     = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    access(0, 17'd9, 8'h00, 64'h0, 0, 0);

    // reset while a read is driving DQ releases the bus immediately
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b0;
    bus.SRAM_BE_N = 8'h00;
    bus.SRAM_ADDR = 17'd5;
    repeat (LAT + 1) tick();
    chk("done_oe", 64'(bus.dbg_dq_oe), 64'hFF);
    rst_n = 1'b0;
    #1;
    chk("rst_done_oe", 64'(bus.dbg_dq_oe), 64'd0);
    chk("rst_done_rdy", 64'(bus.SRAM_RDY), 64'd0);
    bus.SRAM_CE_N = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(($urandom_range(0, 127) << 10) | $urandom_range(0, 15));
      access(bit'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
             {$urandom, $urandom}, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    chk("err_sticky", 64'(bus.SRAM_ERR), 64'(model_err));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
